regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port between the pipeline writeback
//   (requester A, high priority, no backpressure) and the load/MMIO response

---
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: writeback (A) has priority over load responses (B).
// It also keeps a load scoreboard for decode hazards and a starvation guard that stalls the pipeline.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_we,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_value,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_value,
    output logic            ld_ready,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    input  logic [4:0]      src1_num,
    input  logic [4:0]      src2_num,
    output logic            src_hazard,
    output logic            stall_o,
    output logic            rf_we,
    output logic [4:0]      rf_dst,
    output logic [XLEN-1:0] rf_value,
    output logic            proto_err
);

    typedef enum logic [1:0] {IDLE, STALL, GRANT} state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_dst_q, rf_dst_d;
    logic [XLEN-1:0]   rf_value_q, rf_value_d;
    logic [31:0]       busy_q, busy_d;
    logic              err_q, err_d;

    logic              b_acc;
    logic              b_blocked;
    logic              wr_acc;
    logic [4:0]        wr_rd;
    logic              haz1, haz2;

    // Arbitration; a held B response is never taken while reset is asserted.
    assign b_acc     = ld_valid & ~ex_we & ~rst;
    assign b_blocked = ld_valid & ~b_acc;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        starve_d = 4'd0;
        if (b_blocked) begin
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
        end
    end

    // Next-state logic of the starvation guard.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (b_blocked && starve_d == LIMIT) state_d = STALL;
            STALL:   state_d = ld_valid ? GRANT : IDLE;
            GRANT:   if (!ld_valid || b_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs of the guard: stall is the registered decode of the next state.
    always_comb begin
        stall_d  = (state_d == STALL) || (state_d == GRANT);
        ld_ready = b_acc;
    end

    // Write path, scoreboard and protocol checks.
    always_comb begin
        wr_acc     = ex_we | b_acc;
        wr_rd      = ex_we ? ex_rd : ld_rd;
        rf_we_d    = wr_acc && (wr_rd != 5'd0);
        rf_dst_d   = rf_dst_q;
        rf_value_d = rf_value_q;
        if (wr_acc) begin
            rf_dst_d   = wr_rd;
            rf_value_d = ex_we ? ex_value : ld_value;
        end

        // Clear first so that a same-cycle issue to the same register wins.
        busy_d = busy_q;
        if (b_acc) busy_d[ld_rd] = 1'b0;
        if (ld_issue && ld_issue_rd != 5'd0) busy_d[ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;

        err_d = err_q
              | (ld_issue && ld_issue_rd != 5'd0 && busy_q[ld_issue_rd])
              | (b_acc && ld_rd != 5'd0 && !busy_q[ld_rd])
              | (state_q == GRANT && ex_we);
    end

    assign haz1 = (src1_num != 5'd0) && (busy_q[src1_num] || (rf_we_q && rf_dst_q == src1_num));
    assign haz2 = (src2_num != 5'd0) && (busy_q[src2_num] || (rf_we_q && rf_dst_q == src2_num));
    assign src_hazard = haz1 | haz2;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_dst_q   <= 5'd0;
            rf_value_q <= '0;
            // NOTE: the scoreboard is a plain flop vector, so it is cleared on reset like any register.
            busy_q     <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_dst_q   <= rf_dst_d;
            rf_value_q <= rf_value_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign stall_o   = stall_q;
    assign rf_we     = rf_we_q;
    assign rf_dst    = rf_dst_q;
    assign rf_value  = rf_value_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, then random traffic
// compared against a cycle-level reference model.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_we;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_value;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_value;
    logic            ld_ready;
    logic            ld_issue;
    logic [4:0]      ld_issue_rd;
    logic [4:0]      src1_num;
    logic [4:0]      src2_num;
    logic            src_hazard;
    logic            stall_o;
    logic            rf_we;
    logic [4:0]      rf_dst;
    logic [XLEN-1:0] rf_value;
    logic            proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_value(ex_value),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_value(ld_value), .ld_ready(ld_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .src1_num(src1_num), .src2_num(src2_num), .src_hazard(src_hazard),
        .stall_o(stall_o), .rf_we(rf_we), .rf_dst(rf_dst), .rf_value(rf_value),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One row = inputs for one cycle, plus outputs expected in that cycle
    // (registered outputs reflect the previous cycle's inputs).
    typedef struct {
        bit rst; bit ex_we; int ex_rd; int ex_val;
        bit ld_valid; int ld_rd; int ld_val;
        bit iss; int iss_rd; int s1; int s2;
        bit e_rdy; bit e_haz; bit e_stall; bit e_we; int e_dst; int e_val; bit e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit we, int rd, int val, bit lv, int lrd, int lval,
                               bit iss, int ird, int s1, int s2,
                               bit erdy, bit ehaz, bit estall, bit ewe, int edst, int eval, bit eerr);
        vec_t x;
        x.rst = r; x.ex_we = we; x.ex_rd = rd; x.ex_val = val;
        x.ld_valid = lv; x.ld_rd = lrd; x.ld_val = lval;
        x.iss = iss; x.iss_rd = ird; x.s1 = s1; x.s2 = s2;
        x.e_rdy = erdy; x.e_haz = ehaz; x.e_stall = estall; x.e_we = ewe;
        x.e_dst = edst; x.e_val = eval; x.e_err = eerr;
        return x;
    endfunction

    task automatic drive(input bit r, input bit we, input int rd, input int val,
                         input bit lv, input int lrd, input int lval,
                         input bit iss, input int ird, input int s1, input int s2);
        rst = r; ex_we = we; ex_rd = 5'(rd); ex_value = 32'(val);
        ld_valid = lv; ld_rd = 5'(lrd); ld_value = 32'(lval);
        ld_issue = iss; ld_issue_rd = 5'(ird); src1_num = 5'(s1); src2_num = 5'(s2);
    endtask

    // Reference model: streak of blocked cycles, scoreboard array, pending write record.
    bit        m_busy [32];
    bit        m_we;
    int        m_dst;
    int        m_val;
    int        m_streak;
    int        m_phase;   // 0 normal, 1 retire-in-flight stall, 2 forced grant
    bit        m_err;
    bit        m_stall;

    function automatic bit m_ready();
        return ld_valid && !ex_we && !rst;
    endfunction

    function automatic bit m_src_haz(input int n);
        return n != 0 && (m_busy[n] || (m_we && m_dst == n));
    endfunction

    task automatic m_clear();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_we = 0; m_dst = 0; m_val = 0; m_streak = 0; m_phase = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic m_step();
        bit b_ok;
        int wrd;
        if (rst) begin
            m_clear();
            return;
        end
        b_ok = m_ready();
        wrd  = ex_we ? int'(ex_rd) : int'(ld_rd);
        if (ex_we || b_ok) begin
            m_we  = (wrd != 0);
            m_dst = wrd;
            m_val = ex_we ? int'(ex_value) : int'(ld_value);
        end else begin
            m_we = 0;
        end
        if (ld_issue && ld_issue_rd != 0 && m_busy[ld_issue_rd]) m_err = 1;
        if (b_ok && ld_rd != 0 && !m_busy[ld_rd]) m_err = 1;
        if (m_phase == 2 && ex_we) m_err = 1;
        if (b_ok) m_busy[ld_rd] = 0;
        if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1;
        if (ld_valid && !b_ok) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
        else m_streak = 0;
        case (m_phase)
            0: if (ld_valid && !b_ok && m_streak == LIMIT) m_phase = 1;
            1: m_phase = ld_valid ? 2 : 0;
            default: if (!ld_valid || b_ok) m_phase = 0;
        endcase
        m_stall = (m_phase != 0);
    endtask

    initial begin
        bit     b_pend;
        int     b_rd;
        int     b_val;
        bit     r;
        bit     we;
        bit     iss;
        int     ird;
        int     s1;
        int     s2;

        // Directed scenarios.
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,5,'h1234,  0,0,0,     1,7, 0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 5,7, 0,1,0,1,5,'h1234,0));
        tbl.push_back(v(0,1,3,'h11,    1,7,'hAA,  0,0, 0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       1,7,'hAA,  0,0, 0,7, 1,1,0,1,3,'h11,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 7,0, 0,1,0,1,7,'hAA,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     1,8, 7,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,10,'h10A,  1,8,'hBB,  0,0, 0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,11,'h10B,  1,8,'hBB,  0,0, 0,0, 0,0,0,1,10,'h10A,0));
        tbl.push_back(v(0,1,12,'h10C,  1,8,'hBB,  0,0, 0,0, 0,0,0,1,11,'h10B,0));
        tbl.push_back(v(0,1,13,'h10D,  1,8,'hBB,  0,0, 0,0, 0,0,0,1,12,'h10C,0));
        tbl.push_back(v(0,1,14,'h10E,  1,8,'hBB,  0,0, 0,0, 0,0,1,1,13,'h10D,0));
        tbl.push_back(v(0,0,0,0,       1,8,'hBB,  0,0, 8,0, 1,1,1,1,14,'h10E,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 8,0, 0,1,0,1,8,'hBB,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     1,9, 9,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 9,0, 0,1,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       1,9,'h99,  0,0, 9,0, 1,1,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 9,0, 0,1,0,1,9,'h99,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 9,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,'h55,    0,0,0,     1,0, 0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     1,3, 0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     1,3, 0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 3,0, 0,1,0,0,0,0,1));
        tbl.push_back(v(1,0,0,0,       1,3,'h33,  0,0, 0,0, 0,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,       1,3,'h33,  0,0, 3,0, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,       0,0,0,     0,0, 0,0, 0,0,0,1,3,'h33,1));

        drive(1, 0,0,0, 0,0,0, 0,0, 0,0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].ex_we, tbl[i].ex_rd, tbl[i].ex_val,
                  tbl[i].ld_valid, tbl[i].ld_rd, tbl[i].ld_val,
                  tbl[i].iss, tbl[i].iss_rd, tbl[i].s1, tbl[i].s2);
            #1;
            check($sformatf("row%0d ld_ready", i),   32'(ld_ready),   32'(tbl[i].e_rdy));
            check($sformatf("row%0d src_hazard", i), 32'(src_hazard), 32'(tbl[i].e_haz));
            check($sformatf("row%0d stall_o", i),    32'(stall_o),    32'(tbl[i].e_stall));
            check($sformatf("row%0d rf_we", i),      32'(rf_we),      32'(tbl[i].e_we));
            check($sformatf("row%0d proto_err", i),  32'(proto_err),  32'(tbl[i].e_err));
            if (tbl[i].e_we) begin
                check($sformatf("row%0d rf_dst", i),   32'(rf_dst), 32'(tbl[i].e_dst));
                check($sformatf("row%0d rf_value", i), rf_value,    32'(tbl[i].e_val));
            end
        end

        // Randomized traffic against the reference model, starting from reset.
        @(negedge clk);
        drive(1, 0,0,0, 0,0,0, 0,0, 0,0);
        m_clear();
        b_pend = 0; b_rd = 0; b_val = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            r = ($urandom_range(0, 149) == 0);
            if (!b_pend && $urandom_range(0, 2) == 0) begin
                b_pend = 1;
                b_rd   = $urandom_range(1, 31);
                for (int t = 0; t < 8; t++) begin
                    int c;
                    c = $urandom_range(1, 31);
                    if (m_busy[c]) begin
                        b_rd = c;
                        break;
                    end
                end
                b_val = int'($urandom);
            end
            we  = (m_phase == 2) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
            iss = ($urandom_range(0, 3) == 0);
            ird = $urandom_range(0, 31);
            if (m_busy[ird]) ird = $urandom_range(0, 31);
            s1  = $urandom_range(0, 31);
            s2  = $urandom_range(0, 31);
            drive(r, we, $urandom_range(0, 31), int'($urandom),
                  b_pend, b_rd, b_val, iss, ird, s1, s2);
            #1;
            check("rand ld_ready",   32'(ld_ready),   32'(m_ready()));
            check("rand src_hazard", 32'(src_hazard), 32'(m_src_haz(s1) || m_src_haz(s2)));
            check("rand stall_o",    32'(stall_o),    32'(m_stall));
            check("rand rf_we",      32'(rf_we),      32'(m_we));
            check("rand proto_err",  32'(proto_err),  32'(m_err));
            if (m_we) begin
                check("rand rf_dst",   32'(rf_dst), 32'(m_dst));
                check("rand rf_value", rf_value,    32'(m_val));
            end
            if (m_ready()) b_pend = 0;
            m_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
